// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and its decoder:
// FSM state encoding, primary opcode constants, the default reset PC and
// the branch-offset helper used by the next-PC selector.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word offset from a 16-bit branch immediate: sign-extend, then scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus (req/ready handshake).
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : byte address of the word being fetched
//   imem_ready : memory has imem_rdata valid this cycle
//   imem_rdata : fetched instruction word
interface fetch_pc_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC selection for the EXEC slot.
//   i_pc, i_instruction     : current PC and the instruction being executed
//   i_pc_mux_2, i_pc_mux_3  : decoder PC selects (jump / register-indirect)
//   i_beq, i_bne, i_blez    : branch type of the current instruction
//   i_alu_equal, i_rs_lez   : datapath compare flags
//   i_rs_data               : JR target
//   o_next_pc               : selected next PC
//   o_misaligned            : next PC is not word aligned
module next_pc_sel
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instruction,
    input  logic        i_pc_mux_2,
    input  logic        i_pc_mux_3,
    input  logic        i_beq,
    input  logic        i_bne,
    input  logic        i_blez,
    input  logic        i_alu_equal,
    input  logic        i_rs_lez,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_branch_taken;
    logic        w_unused;

    assign w_pc_plus4      = i_pc + 32'd4;
    assign w_jump_target   = {w_pc_plus4[31:28], i_instruction[25:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + branch_offset(i_instruction[15:0]);

    // Several branch flags at once are simply OR-ed together.
    assign w_branch_taken = (i_beq & i_alu_equal) | (i_bne & ~i_alu_equal) |
                            (i_blez & i_rs_lez);

    // Opcode bits are decoded upstream; they play no part in target selection.
    assign w_unused = &{1'b0, i_instruction[31:26]};

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        o_next_pc = w_pc_plus4;
        if (i_pc_mux_3) begin
            o_next_pc = i_rs_data;
        end else if (!i_pc_mux_2) begin
            o_next_pc = w_jump_target;
        end else if (w_branch_taken) begin
            o_next_pc = w_branch_target;
        end
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per slot over the
// imem handshake, presents it to the decoder for one EXEC cycle, then
// latches the next PC. Halt requests and misaligned targets park the stage
// in HALT until reset.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem                : instruction-memory fetch bus (master side)
//   instruction         : registered instruction presented to the decoder
//   instr_valid         : high during the EXEC cycle
//   pc                  : current PC
//   pc_mux_2, pc_mux_3  : decoder PC selects
//   blez, beq, bne      : decoder branch type
//   alu_equal, rs_lez   : datapath compare flags
//   rs_data             : JR target
//   halt_req            : current instruction is halt/syscall
//   halted, fault       : stage is in HALT / misaligned target seen (sticky)
//   retired             : count of completed EXEC slots
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_pc_unit_if.master  imem,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    output logic [31:0]      pc,
    input  logic             pc_mux_2,
    input  logic             pc_mux_3,
    input  logic             blez,
    input  logic             beq,
    input  logic             bne,
    input  logic             alu_equal,
    input  logic             rs_lez,
    input  logic [31:0]      rs_data,
    input  logic             halt_req,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_instruction;
    logic              r_fault;
    logic [CNT_W-1:0]  r_retired;

    logic [31:0]       w_next_pc;
    logic              w_misaligned;
    logic              w_pc_we;
    logic              w_fault_set;

    next_pc_sel u_next_pc_sel (
        .i_pc          (r_pc),
        .i_instruction (r_instruction),
        .i_pc_mux_2    (pc_mux_2),
        .i_pc_mux_3    (pc_mux_3),
        .i_beq         (beq),
        .i_bne         (bne),
        .i_blez        (blez),
        .i_alu_equal   (alu_equal),
        .i_rs_lez      (rs_lez),
        .i_rs_data     (rs_data),
        .o_next_pc     (w_next_pc),
        .o_misaligned  (w_misaligned)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        w_pc_we       = 1'b0;
        w_fault_set   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                // A halt request outranks both the fault check and the PC update.
                if (halt_req) begin
                    w_next_state = ST_HALT;
                end else if (w_misaligned) begin
                    w_next_state = ST_HALT;
                    w_fault_set  = 1'b1;
                end else begin
                    w_next_state = ST_FETCH;
                    w_pc_we      = 1'b1;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instruction <= 32'h0;
            r_fault       <= 1'b0;
            r_retired     <= '0;
        end else begin
            if (r_state == ST_FETCH && imem.imem_ready) begin
                r_instruction <= imem.imem_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_retired <= r_retired + CNT_ONE;
            end
            if (w_pc_we) begin
                r_pc <= w_next_pc;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign imem.imem_addr = r_pc;
    assign instruction    = r_instruction;
    assign pc             = r_pc;
    assign fault          = r_fault;
    assign retired        = r_retired;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset state, sequential fetch, jumps,
// branches, JR, misaligned fault, halt, PC wrap and reset during FETCH.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic        pc_mux_2;
    logic        pc_mux_3;
    logic        blez;
    logic        beq;
    logic        bne;
    logic        alu_equal;
    logic        rs_lez;
    logic [31:0] rs_data;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int n_cmp;
    int n_err;

    fetch_pc_unit_if imem_if ();

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_if),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_mux_2    (pc_mux_2),
        .pc_mux_3    (pc_mux_3),
        .blez        (blez),
        .beq         (beq),
        .bne         (bne),
        .alu_equal   (alu_equal),
        .rs_lez      (rs_lez),
        .rs_data     (rs_data),
        .halt_req    (halt_req),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        pc_mux_2  = 1'b1;
        pc_mux_3  = 1'b0;
        blez      = 1'b0;
        beq       = 1'b0;
        bne       = 1'b0;
        alu_equal = 1'b0;
        rs_lez    = 1'b0;
        rs_data   = 32'h0;
        halt_req  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] rdata);
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = rdata;
        step();
        imem_if.imem_ready = 1'b0;
        imem_if.imem_rdata = 32'h0;
    endtask

    task automatic exec_slot(input logic m2, input logic m3, input logic b_eq,
                             input logic b_ne, input logic b_lez, input logic eq,
                             input logic lez, input logic hreq, input logic [31:0] rs);
        pc_mux_2  = m2;
        pc_mux_3  = m3;
        beq       = b_eq;
        bne       = b_ne;
        blez      = b_lez;
        alu_equal = eq;
        rs_lez    = lez;
        halt_req  = hreq;
        rs_data   = rs;
        step();
        clear_ctrl();
    endtask

    // One-cycle reset pulse between falling edges; returns 1 unit after release.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({imem_if.imem_req, imem_if.imem_addr, pc, instruction} !== {1'b1, 32'h0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_pc_instr: req/addr/pc/instr got %b/%h/%h/%h want 1/0/0/0",
                     imem_if.imem_req, imem_if.imem_addr, pc, instruction);
        end
        n_cmp++;
        if ({instr_valid, halted, fault, retired} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_flags: valid/halted/fault/retired got %b/%b/%b/%0d want 0/0/0/0",
                     instr_valid, halted, fault, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_fetch();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({imem_if.imem_req, imem_if.imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
                n_err++;
                $display("FAIL first_fetch_wait%0d: req/addr/valid got %b/%h/%b want 1/0/0",
                         i, imem_if.imem_req, imem_if.imem_addr, instr_valid);
            end
            if (i == 2) begin
                imem_if.imem_ready = 1'b1;
                imem_if.imem_rdata = 32'h2008_0005;
            end
            step();
        end
        imem_if.imem_ready = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_if.imem_req, instruction} !== {1'b1, 1'b0, 32'h2008_0005}) begin
            n_err++;
            $display("FAIL first_exec: valid/req/instr got %b/%b/%h want 1/0/20080005",
                     instr_valid, imem_if.imem_req, instruction);
        end
        exec_slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, imem_if.imem_addr, retired, instr_valid, imem_if.imem_req} !==
            {32'h4, 32'h4, 32'd1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL first_next: pc/addr/retired/valid/req got %h/%h/%0d/%b/%b want 4/4/1/0/1",
                     pc, imem_if.imem_addr, retired, instr_valid, imem_if.imem_req);
        end
    endtask

    task automatic test_jump();
        fetch(32'h0800_0040);
        exec_slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, retired} !== {32'h0000_0100, 32'd2}) begin
            n_err++;
            $display("FAIL jump_low: pc/retired got %h/%0d want 00000100/2", pc, retired);
        end
    endtask

    task automatic test_branch();
        // BEQ taken with imm -1 loops back onto itself.
        fetch(32'h1000_FFFF);
        exec_slot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL beq_taken: pc got %h want 00000100", pc);
        end
        fetch(32'h1000_FFFF);
        exec_slot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'h0000_0104) begin
            n_err++;
            $display("FAIL beq_not_taken: pc got %h want 00000104", pc);
        end
        fetch(32'h1800_0003);
        exec_slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'h0000_0114) begin
            n_err++;
            $display("FAIL blez_taken: pc got %h want 00000114", pc);
        end
        // BEQ not satisfied but BNE is: flags OR together, so taken.
        fetch(32'h1400_0004);
        exec_slot(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, retired} !== {32'h0000_0128, 32'd6}) begin
            n_err++;
            $display("FAIL multi_flag: pc/retired got %h/%0d want 00000128/6", pc, retired);
        end
    endtask

    task automatic test_jump_region();
        fetch(32'h0000_0008);
        exec_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0010);
        n_cmp++;
        if ({pc, imem_if.imem_addr} !== {32'h1000_0010, 32'h1000_0010}) begin
            n_err++;
            $display("FAIL jr_setup: pc/addr got %h/%h want 10000010/10000010", pc, imem_if.imem_addr);
        end
        fetch(32'h0800_0040);
        exec_slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'h1000_0100) begin
            n_err++;
            $display("FAIL jump_region: pc got %h want 10000100", pc);
        end
        fetch(32'h0800_0040);
        exec_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200);
        n_cmp++;
        if ({pc, retired} !== {32'h0000_0200, 32'd9}) begin
            n_err++;
            $display("FAIL jr_priority: pc/retired got %h/%0d want 00000200/9", pc, retired);
        end
    endtask

    task automatic test_fault();
        fetch(32'h0000_0008);
        exec_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0202);
        n_cmp++;
        if ({fault, halted, pc, imem_if.imem_req, retired} !== {1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'd10}) begin
            n_err++;
            $display("FAIL fault_entry: fault/halted/pc/req/retired got %b/%b/%h/%b/%0d want 1/1/00000200/0/10",
                     fault, halted, pc, imem_if.imem_req, retired);
        end
        for (int i = 0; i < 10; i++) begin
            imem_if.imem_ready = 1'b1;
            imem_if.imem_rdata = 32'hCAFE_0000 + i;
            pc_mux_3 = 1'b1;
            rs_data  = 32'h0000_0400;
            step();
            n_cmp++;
            if ({imem_if.imem_req, instr_valid, halted, fault, pc} !== {1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200}) begin
                n_err++;
                $display("FAIL fault_hold%0d: req/valid/halted/fault/pc got %b/%b/%b/%b/%h want 0/0/1/1/00000200",
                         i, imem_if.imem_req, instr_valid, halted, fault, pc);
            end
        end
        imem_if.imem_ready = 1'b0;
        clear_ctrl();
        pulse_reset();
        n_cmp++;
        if ({pc, fault, halted, retired, imem_if.imem_req} !== {32'h0, 1'b0, 1'b0, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL fault_reset: pc/fault/halted/retired/req got %h/%b/%b/%0d/%b want 0/0/0/0/1",
                     pc, fault, halted, retired, imem_if.imem_req);
        end
        step();
    endtask

    task automatic test_halt();
        fetch(32'h1000_0010);
        exec_slot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        n_cmp++;
        if ({halted, fault, pc, retired, imem_if.imem_req, instr_valid} !==
            {1'b1, 1'b0, 32'h0, 32'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL halt_entry: halted/fault/pc/retired/req/valid got %b/%b/%h/%0d/%b/%b want 1/0/0/1/0/0",
                     halted, fault, pc, retired, imem_if.imem_req, instr_valid);
        end
        pulse_reset();
        n_cmp++;
        if ({halted, retired, imem_if.imem_req} !== {1'b0, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL halt_reset: halted/retired/req got %b/%0d/%b want 0/0/1",
                     halted, retired, imem_if.imem_req);
        end
        step();
    endtask

    task automatic test_wrap();
        fetch(32'h0000_0008);
        exec_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        n_cmp++;
        if (imem_if.imem_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_setup: addr got %h want fffffffc", imem_if.imem_addr);
        end
        fetch(32'h2008_0005);
        exec_slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({pc, retired} !== {32'h0, 32'd2}) begin
            n_err++;
            $display("FAIL wrap: pc/retired got %h/%0d want 00000000/2", pc, retired);
        end
    endtask

    task automatic test_reset_mid_fetch();
        fetch(32'h0000_0008);
        exec_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
        n_cmp++;
        if ({pc, instruction} !== {32'h0000_0040, 32'h0000_0008}) begin
            n_err++;
            $display("FAIL midfetch_setup: pc/instr got %h/%h want 00000040/00000008", pc, instruction);
        end
        // Ready arrives in the same cycle reset is asserted: it must be dropped.
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({instruction, pc, retired, imem_if.imem_req, instr_valid} !==
            {32'h0, 32'h0, 32'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midfetch_reset: instr/pc/retired/req/valid got %h/%h/%0d/%b/%b want 0/0/0/1/0",
                     instruction, pc, retired, imem_if.imem_req, instr_valid);
        end
        imem_if.imem_ready = 1'b0;
        rst_n = 1'b1;
        step();
        fetch(32'h1234_5678);
        n_cmp++;
        if ({instr_valid, instruction, imem_if.imem_addr} !== {1'b1, 32'h1234_5678, 32'h0}) begin
            n_err++;
            $display("FAIL midfetch_refetch: valid/instr/addr got %b/%h/%h want 1/12345678/0",
                     instr_valid, instruction, imem_if.imem_addr);
        end
        exec_slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        imem_if.imem_ready = 1'b0;
        imem_if.imem_rdata = 32'h0;
        clear_ctrl();
        test_reset();
        test_first_fetch();
        test_jump();
        test_branch();
        test_jump_region();
        test_fault();
        test_halt();
        test_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
